// File: rtl/exu_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// exu_lsu_ctrl
// Load/store controller sitting directly after the EX-stage AGU. It takes
// one memory request at a time and runs it on a req/gnt/rvalid data bus.
// While the access is outstanding it stalls the pipeline. Returned load
// data is aligned and extended, then handed to writeback. Misaligned or
// malformed requests are rejected without touching the bus. Bus errors are
// reported with the faulting byte address.
// ---------------------------------------------------------------------------
module exu_lsu_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // AGU request
  input  logic                  i_mem_wen,
  input  logic                  i_mem_ren,
  input  logic [31:0]           i_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_wdata,
  input  logic [3:0]            i_data_be,
  input  logic [2:0]            i_mem_type,
  input  logic                  i_load_unsigned,
  input  logic [4:0]            i_rd_idx,
  output logic                  o_lsu_stall,
  // data bus
  output logic                  o_bus_req,
  output logic                  o_bus_we,
  output logic [31:0]           o_bus_addr,
  output logic [DATA_WIDTH-1:0] o_bus_wdata,
  output logic [3:0]            o_bus_be,
  input  logic                  i_bus_gnt,
  input  logic                  i_bus_rvalid,
  input  logic [DATA_WIDTH-1:0] i_bus_rdata,
  input  logic                  i_bus_err,
  // writeback / exceptions
  output logic                  o_wb_valid,
  output logic [4:0]            o_wb_rd_idx,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  output logic                  o_lsu_err,
  output logic [31:0]           o_err_addr
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  localparam logic [2:0] TYPE_WORD = 3'b001;
  localparam logic [2:0] TYPE_HALF = 3'b010;
  localparam logic [2:0] TYPE_BYTE = 3'b100;

  // Shift the addressed lane down to bit 0, then sign/zero-extend it to the
  // access size. Word accesses are always aligned, so their offset is zero.
  function automatic logic [31:0] load_align(
    input logic [31:0] rdata,
    input logic [1:0]  offset,
    input logic [2:0]  mem_type,
    input logic        is_unsigned
  );
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = rdata >> {offset, 3'b000};
    case (mem_type)
      TYPE_BYTE: begin
        if (is_unsigned) begin
          result = {24'h00_0000, shifted[7:0]};
        end else begin
          result = {{24{shifted[7]}}, shifted[7:0]};
        end
      end
      TYPE_HALF: begin
        if (is_unsigned) begin
          result = {16'h0000, shifted[15:0]};
        end else begin
          result = {{16{shifted[15]}}, shifted[15:0]};
        end
      end
      default: result = shifted;
    endcase
    return result;
  endfunction

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;

  logic        req_present_s;
  logic        type_onehot_s;
  logic        misaligned_s;
  logic        illegal_s;
  logic        accept_s;
  logic        reject_s;

  logic [31:0] addr_r;
  logic [2:0]  type_r;
  logic        unsigned_r;
  logic [4:0]  rd_r;
  logic        is_load_r;

  // Classify the incoming AGU request as legal or illegal.
  always_comb begin
    req_present_s = i_mem_wen | i_mem_ren;
    type_onehot_s = 1'b0;
    misaligned_s  = 1'b0;
    case (i_mem_type)
      TYPE_WORD: begin
        type_onehot_s = 1'b1;
        misaligned_s  = (i_mem_addr[1:0] != 2'b00);
      end
      TYPE_HALF: begin
        type_onehot_s = 1'b1;
        misaligned_s  = (i_mem_addr[1:0] == 2'b11);
      end
      TYPE_BYTE: begin
        type_onehot_s = 1'b1;
        misaligned_s  = 1'b0;
      end
      default: begin
        type_onehot_s = 1'b0;
        misaligned_s  = 1'b0;
      end
    endcase
    illegal_s = (i_mem_wen & i_mem_ren) | ~type_onehot_s | misaligned_s;
    accept_s  = (state_r == ST_IDLE) & req_present_s & ~illegal_s;
    reject_s  = (state_r == ST_IDLE) & req_present_s & illegal_s;
  end

  // Next-state logic for the IDLE -> REQ -> RESP sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (i_bus_gnt) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (i_bus_rvalid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pipeline stall: held from accept until the response arrives. It drops in
  // the rvalid cycle so the pipeline advances on that edge.
  always_comb begin
    o_lsu_stall = accept_s
                | (state_r == ST_REQ)
                | ((state_r == ST_RESP) & ~i_bus_rvalid);
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bus request outputs. They are loaded on accept and held until grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= 32'h0000_0000;
      o_bus_wdata <= '0;
      o_bus_be    <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_mem_wen;
            o_bus_addr  <= {i_mem_addr[31:2], 2'b00};
            o_bus_wdata <= i_mem_wdata;
            o_bus_be    <= i_mem_ren ? 4'b1111 : i_data_be;
          end
        end
        ST_REQ: begin
          if (i_bus_gnt) begin
            o_bus_req <= 1'b0;
          end
        end
        default: begin
          o_bus_req <= 1'b0;
        end
      endcase
    end
  end

  // Capture the request context needed to finish the access.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_r     <= 32'h0000_0000;
      type_r     <= 3'b000;
      unsigned_r <= 1'b0;
      rd_r       <= 5'd0;
      is_load_r  <= 1'b0;
    end else if (accept_s) begin
      addr_r     <= i_mem_addr;
      type_r     <= i_mem_type;
      unsigned_r <= i_load_unsigned;
      rd_r       <= i_rd_idx;
      is_load_r  <= i_mem_ren;
    end
  end

  // Writeback and error pulses. Each pulse lasts one cycle. Load data holds
  // its last value between completions.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb_valid  <= 1'b0;
      o_wb_rd_idx <= 5'd0;
      o_wb_data   <= '0;
      o_lsu_err   <= 1'b0;
      o_err_addr  <= 32'h0000_0000;
    end else begin
      o_wb_valid <= 1'b0;
      o_lsu_err  <= 1'b0;
      if (reject_s) begin
        o_lsu_err  <= 1'b1;
        o_err_addr <= i_mem_addr;
      end else if ((state_r == ST_RESP) && i_bus_rvalid) begin
        if (i_bus_err) begin
          o_lsu_err  <= 1'b1;
          o_err_addr <= addr_r;
        end else if (is_load_r) begin
          o_wb_valid  <= 1'b1;
          o_wb_rd_idx <= rd_r;
          o_wb_data   <= load_align(i_bus_rdata, addr_r[1:0], type_r, unsigned_r);
        end
      end
    end
  end

  exu_lsu_ctrl_chk u_chk (
    .clk        (i_clk),
    .rst        (i_rst),
    .bus_req    (o_bus_req),
    .bus_gnt    (i_bus_gnt),
    .bus_addr   (o_bus_addr),
    .wb_valid   (o_wb_valid),
    .lsu_err    (o_lsu_err)
  );

endmodule

// ---------------------------------------------------------------------------
// exu_lsu_ctrl_chk
// Protocol properties of the load/store controller outputs.
// ---------------------------------------------------------------------------
module exu_lsu_ctrl_chk (
  input logic        clk,
  input logic        rst,
  input logic        bus_req,
  input logic        bus_gnt,
  input logic [31:0] bus_addr,
  input logic        wb_valid,
  input logic        lsu_err
);

  // A completion reports either a result or an error, never both.
  a_wb_err_excl: assert property (@(posedge clk) disable iff (rst)
    !(wb_valid && lsu_err));

  // An ungranted request stays up with a stable address.
  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (bus_req && !bus_gnt) |=> (bus_req && $stable(bus_addr)));

endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exu_lsu_ctrl
// Directed and randomized bench for exu_lsu_ctrl. Expected values come
// from a behavioural model of the access rules: size-based legality and
// arithmetic lane extraction with sign extension.
// ---------------------------------------------------------------------------
module tb_exu_lsu_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_mem_wen, i_mem_ren;
  logic [31:0] i_mem_addr, i_mem_wdata;
  logic [3:0]  i_data_be;
  logic [2:0]  i_mem_type;
  logic        i_load_unsigned;
  logic [4:0]  i_rd_idx;
  logic        o_lsu_stall, o_bus_req, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_gnt, i_bus_rvalid, i_bus_err;
  logic [31:0] i_bus_rdata;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd_idx;
  logic [31:0] o_wb_data;
  logic        o_lsu_err;
  logic [31:0] o_err_addr;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_wb_data = 32'h0;

  always #5 i_clk = ~i_clk;

  exu_lsu_ctrl #(.DATA_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_mem_wen(i_mem_wen), .i_mem_ren(i_mem_ren), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_data_be(i_data_be), .i_mem_type(i_mem_type),
    .i_load_unsigned(i_load_unsigned), .i_rd_idx(i_rd_idx),
    .o_lsu_stall(o_lsu_stall), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
    .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
    .i_bus_err(i_bus_err), .o_wb_valid(o_wb_valid), .o_wb_rd_idx(o_wb_rd_idx),
    .o_wb_data(o_wb_data), .o_lsu_err(o_lsu_err), .o_err_addr(o_err_addr)
  );

  // Model: an access is legal if it is a single direction, of a known size,
  // and (word) aligned to 4 or (half) does not start at byte 3.
  function automatic bit model_legal(input bit w, input bit r, input logic [31:0] a,
                                     input logic [2:0] t);
    int unsigned size;
    if (w && r) return 1'b0;
    if (t == 3'b001) size = 4;
    else if (t == 3'b010) size = 2;
    else if (t == 3'b100) size = 1;
    else return 1'b0;
    if (size == 2) return (a % 4) != 3;
    return (a % size) == 0;
  endfunction

  // Model: pick the addressed lane arithmetically and extend it.
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] a,
                                             input logic [2:0] t, input bit uns);
    longint unsigned v;
    longint unsigned span;
    v = longint'(rdata) / (longint'(1) << (8 * (a % 4)));
    if (t == 3'b100) span = 256;
    else if (t == 3'b010) span = 65536;
    else return rdata;
    v = v % span;
    if (!uns && v >= span / 2) v = v + 64'h1_0000_0000 - span;
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    i_mem_wen = 1'b0; i_mem_ren = 1'b0; i_mem_addr = 32'h0; i_mem_wdata = 32'h0;
    i_data_be = 4'h0; i_mem_type = 3'b000; i_load_unsigned = 1'b0; i_rd_idx = 5'd0;
    i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = 32'h0; i_bus_err = 1'b0;
  endtask

  // One complete access with chosen bus delays, checked cycle by cycle.
  task automatic run_access(input string nm, input bit w, input bit r,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic [2:0] t, input bit uns,
                            input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                            input logic [31:0] rdata, input bit err);
    bit legal;
    logic [31:0] exp_data;
    legal = model_legal(w, r, a, t);
    @(negedge i_clk);
    i_mem_wen = w; i_mem_ren = r; i_mem_addr = a; i_mem_wdata = wd; i_data_be = be;
    i_mem_type = t; i_load_unsigned = uns; i_rd_idx = rd;
    #1;
    checks++; if (o_lsu_stall !== legal) begin failures++; $display("FAIL %s accept_stall got=%b exp=%b", nm, o_lsu_stall, legal); end
    checks++; if (o_bus_req !== 1'b0) begin failures++; $display("FAIL %s accept_req got=%b exp=0", nm, o_bus_req); end
    @(negedge i_clk);
    idle_inputs();
    #1;
    if (!legal) begin
      checks++; if (o_lsu_err !== 1'b1 || o_err_addr !== a) begin failures++; $display("FAIL %s illegal_err got=%b/%h exp=1/%h", nm, o_lsu_err, o_err_addr, a); end
      checks++; if (o_bus_req !== 1'b0 || o_lsu_stall !== 1'b0) begin failures++; $display("FAIL %s illegal_nobus req=%b stall=%b exp=0/0", nm, o_bus_req, o_lsu_stall); end
      @(negedge i_clk); #1;
      checks++; if (o_lsu_err !== 1'b0) begin failures++; $display("FAIL %s illegal_pulse got=%b exp=0", nm, o_lsu_err); end
      return;
    end
    // REQ phase: request visible and stable until grant
    for (int k = 0; k <= gnt_dly; k++) begin
      checks++; if (o_bus_req !== 1'b1 || o_lsu_stall !== 1'b1) begin failures++; $display("FAIL %s req_hold k=%0d req=%b stall=%b exp=1/1", nm, k, o_bus_req, o_lsu_stall); end
      checks++; if (o_bus_addr !== {a[31:2], 2'b00} || o_bus_we !== w) begin failures++; $display("FAIL %s req_addr got=%h/%b exp=%h/%b", nm, o_bus_addr, o_bus_we, {a[31:2], 2'b00}, w); end
      checks++; if (o_bus_be !== (r ? 4'hF : be)) begin failures++; $display("FAIL %s req_be got=%h exp=%h", nm, o_bus_be, (r ? 4'hF : be)); end
      if (w) begin
        checks++; if (o_bus_wdata !== wd) begin failures++; $display("FAIL %s req_wdata got=%h exp=%h", nm, o_bus_wdata, wd); end
      end
      if (k == gnt_dly) i_bus_gnt = 1'b1;
      @(negedge i_clk);
      i_bus_gnt = 1'b0;
      #1;
    end
    // RESP phase: request dropped, stall held until rvalid
    for (int k = 1; k < rv_dly; k++) begin
      checks++; if (o_bus_req !== 1'b0 || o_lsu_stall !== 1'b1) begin failures++; $display("FAIL %s resp_wait req=%b stall=%b exp=0/1", nm, o_bus_req, o_lsu_stall); end
      @(negedge i_clk); #1;
    end
    checks++; if (o_bus_req !== 1'b0) begin failures++; $display("FAIL %s resp_req got=%b exp=0", nm, o_bus_req); end
    i_bus_rvalid = 1'b1; i_bus_rdata = rdata; i_bus_err = err;
    #1;
    checks++; if (o_lsu_stall !== 1'b0) begin failures++; $display("FAIL %s rvalid_stall got=%b exp=0", nm, o_lsu_stall); end
    @(negedge i_clk);
    idle_inputs();
    #1;
    if (r && !err) begin
      exp_data = model_load(rdata, a, t, uns);
      last_wb_data = exp_data;
      checks++; if (o_wb_valid !== 1'b1 || o_wb_rd_idx !== rd) begin failures++; $display("FAIL %s wb_valid got=%b/%0d exp=1/%0d", nm, o_wb_valid, o_wb_rd_idx, rd); end
      checks++; if (o_wb_data !== exp_data) begin failures++; $display("FAIL %s wb_data got=%h exp=%h", nm, o_wb_data, exp_data); end
    end else begin
      checks++; if (o_wb_valid !== 1'b0) begin failures++; $display("FAIL %s no_wb got=%b exp=0", nm, o_wb_valid); end
    end
    checks++; if (o_lsu_err !== err) begin failures++; $display("FAIL %s bus_err got=%b exp=%b", nm, o_lsu_err, err); end
    if (err) begin
      checks++; if (o_err_addr !== a) begin failures++; $display("FAIL %s err_addr got=%h exp=%h", nm, o_err_addr, a); end
    end
    @(negedge i_clk); #1;
    checks++; if (o_wb_valid !== 1'b0 || o_lsu_err !== 1'b0) begin failures++; $display("FAIL %s pulse_end wb=%b err=%b exp=0/0", nm, o_wb_valid, o_lsu_err); end
    checks++; if (o_wb_data !== last_wb_data) begin failures++; $display("FAIL %s wb_hold got=%h exp=%h", nm, o_wb_data, last_wb_data); end
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1'b1;
    i_bus_rvalid = 1'b1; i_bus_gnt = 1'b1;
    repeat (2) @(negedge i_clk);
    #1;
    checks++; if ({o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be} !== 70'h0) begin failures++; $display("FAIL reset_bus req=%b we=%b addr=%h wdata=%h be=%h exp=all 0", o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be); end
    checks++; if ({o_wb_valid, o_wb_rd_idx, o_wb_data, o_lsu_err, o_err_addr} !== 71'h0) begin failures++; $display("FAIL reset_wb wb=%b rd=%0d data=%h err=%b eaddr=%h exp=all 0", o_wb_valid, o_wb_rd_idx, o_wb_data, o_lsu_err, o_err_addr); end
    checks++; if (o_lsu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", o_lsu_stall); end
    i_rst = 1'b0;
    // stale response after reset must be ignored
    @(negedge i_clk);
    idle_inputs();
    #1;
    checks++; if (o_wb_valid !== 1'b0 || o_lsu_err !== 1'b0 || o_bus_req !== 1'b0) begin failures++; $display("FAIL stale_resp wb=%b err=%b req=%b exp=0/0/0", o_wb_valid, o_lsu_err, o_bus_req); end
    last_wb_data = 32'h0;
  endtask

  task automatic test_directed();
    run_access("word_load", 1'b0, 1'b1, 32'h100, 32'h0, 4'h0, 3'b001, 1'b0, 5'd7, 0, 2, 32'h8000_00FF, 1'b0);
    run_access("byte_signed", 1'b0, 1'b1, 32'h103, 32'h0, 4'h0, 3'b100, 1'b0, 5'd3, 1, 1, 32'h8100_0000, 1'b0);
    run_access("byte_unsigned", 1'b0, 1'b1, 32'h103, 32'h0, 4'h0, 3'b100, 1'b1, 5'd4, 0, 1, 32'h8100_0000, 1'b0);
    run_access("half_store", 1'b1, 1'b0, 32'h202, 32'hBEEF_0000, 4'b1100, 3'b010, 1'b0, 5'd0, 3, 2, 32'h0, 1'b0);
    run_access("half_load_hi", 1'b0, 1'b1, 32'h206, 32'h0, 4'h0, 3'b010, 1'b0, 5'd9, 0, 1, 32'h9ABC_1234, 1'b0);
    run_access("mis_word", 1'b0, 1'b1, 32'h101, 32'h0, 4'h0, 3'b001, 1'b0, 5'd1, 0, 1, 32'h0, 1'b0);
    run_access("mis_half", 1'b0, 1'b1, 32'h103, 32'h0, 4'h0, 3'b010, 1'b0, 5'd1, 0, 1, 32'h0, 1'b0);
    run_access("both_en", 1'b1, 1'b1, 32'h400, 32'h0, 4'hF, 3'b001, 1'b0, 5'd1, 0, 1, 32'h0, 1'b0);
    run_access("bad_type", 1'b0, 1'b1, 32'h400, 32'h0, 4'h0, 3'b011, 1'b0, 5'd1, 0, 1, 32'h0, 1'b0);
    run_access("load_buserr", 1'b0, 1'b1, 32'h300, 32'h0, 4'h0, 3'b001, 1'b0, 5'd5, 0, 1, 32'hDEAD_BEEF, 1'b1);
    run_access("store_buserr", 1'b1, 1'b0, 32'h305, 32'h0000_AB00, 4'b0010, 3'b100, 1'b0, 5'd0, 2, 3, 32'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge i_clk);
    i_mem_ren = 1'b1; i_mem_addr = 32'h500; i_mem_type = 3'b001; i_rd_idx = 5'd11;
    @(negedge i_clk);
    idle_inputs();
    i_bus_gnt = 1'b1;
    @(negedge i_clk);
    i_bus_gnt = 1'b0;
    #1;
    checks++; if (o_lsu_stall !== 1'b1) begin failures++; $display("FAIL mid_pre_stall got=%b exp=1", o_lsu_stall); end
    i_rst = 1'b1;
    #1;
    checks++; if (o_bus_req !== 1'b0 || o_lsu_stall !== 1'b0 || o_bus_addr !== 32'h0) begin failures++; $display("FAIL mid_reset req=%b stall=%b addr=%h exp=0/0/0", o_bus_req, o_lsu_stall, o_bus_addr); end
    @(negedge i_clk);
    i_rst = 1'b0;
    i_bus_rvalid = 1'b1; i_bus_rdata = 32'h1234_5678;
    @(negedge i_clk);
    idle_inputs();
    #1;
    checks++; if (o_wb_valid !== 1'b0 || o_lsu_err !== 1'b0 || o_wb_data !== 32'h0) begin failures++; $display("FAIL mid_no_wb wb=%b err=%b data=%h exp=0/0/0", o_wb_valid, o_lsu_err, o_wb_data); end
    last_wb_data = 32'h0;
  endtask

  task automatic test_random();
    logic [2:0] types [4];
    types[0] = 3'b001; types[1] = 3'b010; types[2] = 3'b100; types[3] = 3'b000;
    for (int n = 0; n < 60; n++) begin
      bit w, r;
      logic [2:0] t;
      int sel;
      sel = $urandom_range(0, 9);
      w = (sel < 4) || (sel == 9);
      r = (sel >= 4);
      t = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : types[$urandom_range(0, 2)];
      run_access("random", w, r, $urandom, $urandom, 4'($urandom_range(0, 15)), t,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 3), $urandom_range(1, 3), $urandom,
                 ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic test_back_to_back();
    run_access("b2b_load0", 1'b0, 1'b1, 32'h600, 32'h0, 4'h0, 3'b001, 1'b0, 5'd20, 0, 1, 32'h0F0F_F0F0, 1'b0);
    run_access("b2b_store", 1'b1, 1'b0, 32'h601, 32'h0000_5A00, 4'b0010, 3'b100, 1'b0, 5'd0, 0, 1, 32'h0, 1'b0);
    run_access("b2b_load1", 1'b0, 1'b1, 32'h601, 32'h0, 4'h0, 3'b010, 1'b1, 5'd21, 0, 1, 32'h00F0_8000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
